// File: rtl/move_scheduler.sv
// Button front-end for the 2048 game: synchronizes and debounces the five keys,
// arbitrates presses and hands moves to the game FSM over a valid/ack handshake.
module move_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       busy,
  input  logic       game_over,
  input  logic       move_ack,
  output logic       start_pulse,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       pending,
  output logic [7:0] dropped_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    OFFER_PEND
  } state_t;

  // Button bit order: 0 start, 1 up, 2 down, 3 left, 4 right.
  logic [4:0]       raw_n;
  logic [4:0]       sync1_n;
  logic [4:0]       sync2_n;
  logic [4:0]       level;
  logic [4:0]       stable;
  logic [4:0]       stable_d;
  logic [4:0]       press;
  logic [CNT_W-1:0] cnt [5];

  state_t     state;
  logic [1:0] pend_dir;
  logic       start_ev;
  logic       dir_ev;
  logic [1:0] ev_dir;
  logic       ack;

  assign raw_n = {btn_right_n, btn_left_n, btn_down_n, btn_up_n, btn_start_n};
  assign level = ~sync2_n;
  assign press = stable & ~stable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int unsigned i = 0; i < 5; i++) begin
        if (level[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    start_ev = press[0];
    dir_ev   = 1'b0;
    ev_dir   = 2'b00;
    if (!press[0]) begin
      if (press[1]) begin
        dir_ev = 1'b1;
        ev_dir = 2'b00;
      end else if (press[2]) begin
        dir_ev = 1'b1;
        ev_dir = 2'b01;
      end else if (press[3]) begin
        dir_ev = 1'b1;
        ev_dir = 2'b10;
      end else if (press[4]) begin
        dir_ev = 1'b1;
        ev_dir = 2'b11;
      end
    end
  end

  assign move_valid = (state != IDLE) && !busy && !game_over;
  assign pending    = (state == OFFER_PEND);
  assign ack        = move_ack && move_valid;

  // Ack is applied before a same-cycle direction event, so an event arriving
  // with the ack refills the freed position instead of being dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      start_pulse   <= 1'b0;
      move_dir      <= 2'b00;
      pend_dir      <= 2'b00;
      dropped_count <= '0;
    end else begin
      start_pulse <= 1'b0;
      if (start_ev) begin
        start_pulse <= 1'b1;
        state       <= IDLE;
      end else if (game_over) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (dir_ev) begin
              move_dir <= ev_dir;
              state    <= OFFER;
            end
          end
          OFFER: begin
            if (ack) begin
              if (dir_ev) begin
                move_dir <= ev_dir;
              end else begin
                state <= IDLE;
              end
            end else if (dir_ev) begin
              pend_dir <= ev_dir;
              state    <= OFFER_PEND;
            end
          end
          OFFER_PEND: begin
            if (ack) begin
              move_dir <= pend_dir;
              if (dir_ev) begin
                pend_dir <= ev_dir;
              end else begin
                state <= OFFER;
              end
            end else if (dir_ev && (dropped_count != 8'hFF)) begin
              dropped_count <= dropped_count + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a short debounce window.
module tb_move_scheduler;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [4:0] btn;
  logic       busy;
  logic       game_over;
  logic       move_ack;
  logic       start_pulse;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       pending;
  logic [7:0] dropped_count;

  int n_tests;
  int n_fail;

  move_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start_n(btn[0]),
    .btn_up_n(btn[1]),
    .btn_down_n(btn[2]),
    .btn_left_n(btn[3]),
    .btn_right_n(btn[4]),
    .busy(busy),
    .game_over(game_over),
    .move_ack(move_ack),
    .start_pulse(start_pulse),
    .move_valid(move_valid),
    .move_dir(move_dir),
    .pending(pending),
    .dropped_count(dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] mask;
    logic       exp_start;
    logic       exp_valid;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic press_release(input logic [4:0] mask);
    btn = ~mask;
    repeat (3 + D) tick();
    btn = '1;
    repeat (3 + D) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    logic got;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{5'b00010, 1'b0, 1'b1, 2'b00};
    vecs[1] = '{5'b00100, 1'b0, 1'b1, 2'b01};
    vecs[2] = '{5'b01000, 1'b0, 1'b1, 2'b10};
    vecs[3] = '{5'b10000, 1'b0, 1'b1, 2'b11};
    vecs[4] = '{5'b00001, 1'b1, 1'b0, 2'b00};
    vecs[5] = '{5'b10001, 1'b1, 1'b0, 2'b00};
    vecs[6] = '{5'b01010, 1'b0, 1'b1, 2'b00};
    vecs[7] = '{5'b10100, 1'b0, 1'b1, 2'b01};
    vecs[8] = '{5'b11000, 1'b0, 1'b1, 2'b10};
    vecs[9] = '{5'b11111, 1'b1, 1'b0, 2'b00};

    rst       = 1'b0;
    btn       = '1;
    busy      = 1'b0;
    game_over = 1'b0;
    move_ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", start_pulse, 0);
    chk("rst_valid", move_valid, 0);
    chk("rst_dir", move_dir, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", dropped_count, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Table: single and simultaneous presses from idle.
    for (int v = 0; v < 10; v++) begin
      btn = ~vecs[v].mask;
      repeat (2 + D) tick();
      chk("early", {start_pulse, move_valid}, 0);
      tick();
      chk("start", start_pulse, vecs[v].exp_start);
      chk("valid", move_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) chk("dir", move_dir, vecs[v].exp_dir);
      btn = '1;
      tick();
      chk("one_shot", start_pulse, 0);
      repeat (2 + D) tick();
      chk("hold_valid", move_valid, vecs[v].exp_valid);
      chk("hold_pend", pending, 0);
      if (vecs[v].exp_valid) begin
        move_ack = 1'b1;
        tick();
        move_ack = 1'b0;
        chk("ack_clear", move_valid, 0);
      end
    end
    chk("table_drop", dropped_count, 0);

    // Bounce on left, then a steady hold.
    for (int c = 0; c < 20; c++) begin
      btn = (((c / 2) % 2) == 0) ? 5'b10111 : 5'b11111;
      tick();
      if (move_valid || start_pulse) chk("bounce_quiet", {start_pulse, move_valid}, 0);
    end
    btn = 5'b10111;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30 && !got; c++) begin
      tick();
      if (move_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("bounce_latency", lat, 3 + D);
    chk("bounce_dir", move_dir, 2'b10);
    btn = '1;
    repeat (3 + D) tick();
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    chk("bounce_single", move_valid, 0);

    // Buffering while busy, plus an ack that must be ignored.
    busy = 1'b1;
    press_release(5'b00100);
    press_release(5'b10000);
    press_release(5'b00010);
    chk("busy_valid", move_valid, 0);
    chk("busy_dir", move_dir, 2'b01);
    chk("busy_pend", pending, 1);
    chk("busy_drop", dropped_count, 1);
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    chk("ign_ack_pend", pending, 1);
    chk("ign_ack_dir", move_dir, 2'b01);
    busy = 1'b0;
    #1;
    chk("unbusy_valid", move_valid, 1);
    move_ack = 1'b1;
    tick();
    chk("ack1_valid", move_valid, 1);
    chk("ack1_dir", move_dir, 2'b11);
    chk("ack1_pend", pending, 0);
    tick();
    move_ack = 1'b0;
    chk("ack2_valid", move_valid, 0);

    // Game over clears the slot and buffer; start still works.
    busy = 1'b1;
    press_release(5'b00100);
    press_release(5'b01000);
    busy = 1'b0;
    #1;
    chk("go_pre_valid", move_valid, 1);
    chk("go_pre_pend", pending, 1);
    game_over = 1'b1;
    tick();
    chk("go_valid", move_valid, 0);
    chk("go_pend", pending, 0);
    press_release(5'b00100);
    game_over = 1'b0;
    #1;
    chk("go_ignored_valid", move_valid, 0);
    chk("go_ignored_pend", pending, 0);
    game_over = 1'b1;
    btn = 5'b11110;
    repeat (3 + D) tick();
    chk("go_start", start_pulse, 1);
    btn = '1;
    repeat (3 + D) tick();
    game_over = 1'b0;
    chk("go_drop", dropped_count, 1);

    // Asynchronous reset while OFFER_PEND with five drops recorded.
    busy = 1'b1;
    press_release(5'b00100);
    press_release(5'b10000);
    for (int k = 0; k < 4; k++) press_release(5'b01000);
    busy = 1'b0;
    #1;
    chk("prerst_drop", dropped_count, 5);
    chk("prerst_valid", move_valid, 1);
    chk("prerst_pend", pending, 1);
    btn = 5'b11101;
    repeat (2) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_start", start_pulse, 0);
    chk("arst_valid", move_valid, 0);
    chk("arst_dir", move_dir, 0);
    chk("arst_pend", pending, 0);
    chk("arst_drop", dropped_count, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2 + D; c++) begin
      tick();
      chk("post_rst_quiet", {start_pulse, move_valid}, 0);
    end
    tick();
    chk("post_rst_valid", move_valid, 1);
    chk("post_rst_dir", move_dir, 2'b00);
    btn = '1;
    repeat (3 + D) tick();
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;

    // Drop counter saturation.
    busy = 1'b1;
    press_release(5'b00100);
    press_release(5'b10000);
    for (int k = 0; k < 255; k++) press_release(5'b00010);
    chk("sat_255", dropped_count, 255);
    press_release(5'b00010);
    chk("sat_hold", dropped_count, 255);
    chk("sat_dir", move_dir, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
